// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle logic/add/sub, iterative shift-add multiply and restoring divide.
// Define ALU_MC_DIVIDE_EN to build the divider; otherwise opcode 4 reports error in one cycle.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] extra,
   output logic             error
);

   typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_ITER, S_FINISH} state_t;
   typedef enum logic [2:0] {
      OP_AND = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3,
      OP_DIV = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_PASS = 3'd7
   } op_t;

   state_t           state;
   op_t              op_q;
   logic [WIDTH-1:0] opa, opb;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [CNT_W-1:0] count;

   logic [WIDTH:0]   add_sum, sub_diff, mul_sum;
   logic [WIDTH-1:0] s_res, s_ext;
   logic             s_err;
   logic             go_iter;

   assign add_sum  = {1'b0, opa} + {1'b0, opb};
   assign sub_diff = {1'b0, opa} - {1'b0, opb};
   // {acc_hi,acc_lo} is the shifting product; acc_lo starts as the multiplier
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);

`ifdef ALU_MC_DIVIDE_EN
   logic [WIDTH:0] div_trial, div_diff;
   // acc_hi is the partial remainder, acc_lo the dividend shifting into the quotient
   assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_trial - {1'b0, opb};
`endif

   always_comb begin
      go_iter = (control == OP_MUL);
`ifdef ALU_MC_DIVIDE_EN
      if (control == OP_DIV && op2 != '0)
         go_iter = 1'b1;
`endif
   end

   always_comb begin
      s_res = '0;
      s_ext = '0;
      s_err = 1'b0;
      case (op_q)
         OP_AND:  s_res = opa & opb;
         OP_ADD:  begin
            s_res = add_sum[WIDTH-1:0];
            s_ext = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
         end
         OP_SUB:  begin
            s_res = sub_diff[WIDTH-1:0];
            s_ext = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
         end
         OP_DIV:  begin
`ifdef ALU_MC_DIVIDE_EN
            s_res = '1;
            s_ext = opa;
`endif
            s_err = 1'b1;
         end
         OP_OR:   s_res = opa | opb;
         OP_XOR:  s_res = opa ^ opb;
         OP_PASS: s_res = opa;
         default: s_res = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         op_q   <= OP_AND;
         opa    <= '0;
         opb    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
         result <= '0;
         extra  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q   <= op_t'(control);
                  opa    <= op1;
                  opb    <= op2;
                  acc_hi <= '0;
                  acc_lo <= (control == OP_MUL) ? op2 : op1;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= go_iter ? S_ITER : S_SINGLE;
               end
            end
            S_SINGLE: begin
               result <= s_res;
               extra  <= s_ext;
               error  <= s_err;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            S_ITER: begin
`ifdef ALU_MC_DIVIDE_EN
               if (op_q == OP_DIV) begin
                  if (!div_diff[WIDTH]) begin
                     acc_hi <= div_diff[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= div_trial[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
`else
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1))
                  state <= S_FINISH;
            end
            S_FINISH: begin
               result <= acc_lo;
               extra  <= acc_hi;
               error  <= 1'b0;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
